// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C master sequencer.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_STOP
  } i2c_seq_state_t;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_t;

  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;
  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;

  // Next quarter, wrapping Q3 back to Q0.
  function automatic quarter_t quarter_inc(input quarter_t q);
    return quarter_t'(2'(q) + 2'd1);
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL timebase: CLK_DIV divider producing a tick, plus the 2-bit quarter counter.
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  logic     clr,
  output logic     tick_c,
  output quarter_t q
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  assign tick_c = en && !clr && (div == DIV_LAST);

  // Divider and quarter counter; held at zero while cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      q   <= Q0;
    end else if (clr) begin
      div <= '0;
      q   <= Q0;
    end else if (en) begin
      if (tick_c) begin
        div <= '0;
        q   <= quarter_inc(q);
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_master_seq.sv
// Single-command I2C master: START, address+R/W, ACK, N data bytes, STOP.
module i2c_master_seq
  import i2c_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_rw,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  nack_error,
  output logic                  busy,
  output logic                  scl_out,
  output logic                  sda_out,
  input  logic                  sda_in
);

  localparam int unsigned FRAME_W = ADDR_WIDTH + 1;
  localparam int unsigned MAX_W   = (FRAME_W > DATA_WIDTH) ? FRAME_W : DATA_WIDTH;
  localparam int unsigned BIT_W   = $clog2(MAX_W);
  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);

  i2c_seq_state_t state, state_nxt;
  quarter_t       q, q_nxt;
  logic           tick_c;
  logic           slot_end_c;
  logic           sample_c;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  byte_cnt, byte_cnt_d;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_byte, tx_byte_d;
  logic [DATA_WIDTH-1:0] rx_byte, rx_byte_d;
  logic                  ack_bit, ack_bit_d;
  logic                  err, err_d;

  logic [DATA_WIDTH-1:0] rd_data_d;
  logic                  rd_valid_d, wr_pop_d, done_d, nack_error_d;
  logic                  busy_d, cmd_ready_d, scl_d, sda_d;
  logic [FRAME_W-1:0]    frame_sh;
  logic [DATA_WIDTH-1:0] tx_sh;

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state != ST_IDLE),
    .clr    (state == ST_IDLE),
    .tick_c (tick_c),
    .q      (q)
  );

  assign slot_end_c = tick_c && (q == Q3);
  assign sample_c   = tick_c && (q == Q2);
  assign q_nxt      = tick_c ? quarter_inc(q) : q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: transitions happen only at bit-slot boundaries once running.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (cmd_valid) state_nxt = ST_START;
      ST_START:     if (slot_end_c) state_nxt = ST_ADDR;
      ST_ADDR:      if (slot_end_c && bit_cnt == ADDR_LAST) state_nxt = ST_ADDR_ACK;
      ST_ADDR_ACK:
        if (slot_end_c) begin
          if (ack_bit == I2C_NACK)   state_nxt = ST_STOP;
          else if (len_q == '0)      state_nxt = ST_STOP;
          else if (rw_q == I2C_WRITE) state_nxt = ST_WRITE;
          else                       state_nxt = ST_READ;
        end
      ST_WRITE:     if (slot_end_c && bit_cnt == DATA_LAST) state_nxt = ST_WRITE_ACK;
      ST_WRITE_ACK:
        if (slot_end_c) begin
          if (ack_bit == I2C_NACK || (byte_cnt + LEN_WIDTH'(1)) == len_q) state_nxt = ST_STOP;
          else state_nxt = ST_WRITE;
        end
      ST_READ:      if (slot_end_c && bit_cnt == DATA_LAST) state_nxt = ST_READ_ACK;
      ST_READ_ACK:
        if (slot_end_c) begin
          if ((byte_cnt + LEN_WIDTH'(1)) == len_q) state_nxt = ST_STOP;
          else state_nxt = ST_READ;
        end
      ST_STOP:      if (slot_end_c) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Outputs and datapath next values; bus lines follow the next state/quarter.
  always_comb begin
    addr_d       = addr_q;
    rw_d         = rw_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt;
    bit_cnt_d    = bit_cnt;
    tx_byte_d    = tx_byte;
    rx_byte_d    = rx_byte;
    ack_bit_d    = ack_bit;
    err_d        = err;
    rd_data_d    = rd_data;
    rd_valid_d   = 1'b0;
    wr_pop_d     = 1'b0;
    done_d       = 1'b0;
    nack_error_d = 1'b0;
    scl_d        = 1'b1;
    sda_d        = 1'b1;
    frame_sh     = '0;
    tx_sh        = '0;

    case (state)
      ST_IDLE:
        if (cmd_valid) begin
          addr_d     = cmd_addr;
          rw_d       = cmd_rw;
          len_d      = cmd_len;
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          err_d      = 1'b0;
        end
      ST_ADDR:
        if (slot_end_c) bit_cnt_d = (bit_cnt == ADDR_LAST) ? '0 : bit_cnt + BIT_W'(1);
      ST_ADDR_ACK: begin
        if (sample_c) ack_bit_d = sda_in;
        if (slot_end_c && ack_bit == I2C_NACK) err_d = 1'b1;
      end
      ST_WRITE:
        if (slot_end_c) bit_cnt_d = (bit_cnt == DATA_LAST) ? '0 : bit_cnt + BIT_W'(1);
      ST_WRITE_ACK: begin
        if (sample_c) ack_bit_d = sda_in;
        if (slot_end_c) begin
          byte_cnt_d = byte_cnt + LEN_WIDTH'(1);
          if (ack_bit == I2C_NACK) err_d = 1'b1;
        end
      end
      ST_READ: begin
        if (sample_c) rx_byte_d = {rx_byte[DATA_WIDTH-2:0], sda_in};
        if (slot_end_c) begin
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_d  = '0;
            rd_data_d  = rx_byte;
            rd_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt + BIT_W'(1);
          end
        end
      end
      ST_READ_ACK:
        if (slot_end_c) byte_cnt_d = byte_cnt + LEN_WIDTH'(1);
      ST_STOP:
        if (state_nxt == ST_IDLE) begin
          done_d       = 1'b1;
          nack_error_d = err;
        end
      default: ;
    endcase

    // Entering a write byte consumes the presented wr_data.
    if (state_nxt == ST_WRITE && state != ST_WRITE) begin
      tx_byte_d = wr_data;
      wr_pop_d  = 1'b1;
    end

    frame_sh = {addr_d, rw_d} << bit_cnt_d;
    tx_sh    = tx_byte_d << bit_cnt_d;

    case (state_nxt)
      ST_IDLE:     begin scl_d = 1'b1; sda_d = 1'b1; end
      ST_START:    begin scl_d = 1'b1; sda_d = (q_nxt == Q0 || q_nxt == Q1); end
      ST_ADDR:     begin scl_d = (q_nxt == Q2 || q_nxt == Q3); sda_d = frame_sh[FRAME_W-1]; end
      ST_WRITE:    begin scl_d = (q_nxt == Q2 || q_nxt == Q3); sda_d = tx_sh[DATA_WIDTH-1]; end
      ST_READ_ACK: begin
        scl_d = (q_nxt == Q2 || q_nxt == Q3);
        sda_d = ((byte_cnt_d + LEN_WIDTH'(1)) < len_d) ? I2C_ACK : I2C_NACK;
      end
      ST_STOP:     begin scl_d = (q_nxt == Q2 || q_nxt == Q3); sda_d = (q_nxt == Q3); end
      default:     begin scl_d = (q_nxt == Q2 || q_nxt == Q3); sda_d = 1'b1; end
    endcase

    busy_d      = (state_nxt != ST_IDLE);
    cmd_ready_d = (state_nxt == ST_IDLE);
  end

  // Datapath and registered outputs; reset releases both bus lines at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rw_q       <= 1'b0;
      len_q      <= '0;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      tx_byte    <= '0;
      rx_byte    <= '0;
      ack_bit    <= 1'b1;
      err        <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      wr_pop     <= 1'b0;
      done       <= 1'b0;
      nack_error <= 1'b0;
      busy       <= 1'b0;
      cmd_ready  <= 1'b1;
      scl_out    <= 1'b1;
      sda_out    <= 1'b1;
    end else begin
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      len_q      <= len_d;
      byte_cnt   <= byte_cnt_d;
      bit_cnt    <= bit_cnt_d;
      tx_byte    <= tx_byte_d;
      rx_byte    <= rx_byte_d;
      ack_bit    <= ack_bit_d;
      err        <= err_d;
      rd_data    <= rd_data_d;
      rd_valid   <= rd_valid_d;
      wr_pop     <= wr_pop_d;
      done       <= done_d;
      nack_error <= nack_error_d;
      busy       <= busy_d;
      cmd_ready  <= cmd_ready_d;
      scl_out    <= scl_d;
      sda_out    <= sda_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench for i2c_master_seq with a bit-level slave model and scoreboard queues.
module tb_i2c_master_seq;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 7;
  localparam int unsigned CD = 4;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_rw;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_pop;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          nack_error;
  logic          busy;
  logic          scl_out;
  logic          sda_out;
  logic          sda_in;
  logic          slave_sda;

  assign sda_in = sda_out & slave_sda;

  always #5 clk = ~clk;

  i2c_master_seq #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CLK_DIV    (CD),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_rw     (cmd_rw),
    .cmd_len    (cmd_len),
    .wr_data    (wr_data),
    .wr_pop     (wr_pop),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .done       (done),
    .nack_error (nack_error),
    .busy       (busy),
    .scl_out    (scl_out),
    .sda_out    (sda_out),
    .sda_in     (sda_in)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  bit          exp_bits[$];
  bit          slave_q[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  wr_q[$];
  int          wr_cnt;
  int          rd_cnt;
  int          extra;
  logic        scl_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  task automatic exp_bit(input bit b);
    exp_bits.push_back(b);
  endtask

  task automatic slv_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) slave_q.push_back(b[i]);
  endtask

  task automatic slv_bit(input bit b);
    slave_q.push_back(b);
  endtask

  task automatic slv_rel(input int n);
    for (int i = 0; i < n; i++) slave_q.push_back(1'b1);
  endtask

  task automatic clear_sb();
    exp_bits.delete();
    slave_q.delete();
    exp_rd.delete();
    wr_q.delete();
    slave_sda = 1'b1;
  endtask

  // One command: drive it, watch the bus cycle by cycle, check the scoreboard at done.
  task automatic run(input logic [AW-1:0] addr, input logic rw, input logic [LW-1:0] len,
                     input int exp_lat, input logic exp_nack, input int exp_wr, input int exp_rdn,
                     input int poke_at, input int rst_at);
    int lat;
    bit fin;
    wr_cnt = 0;
    rd_cnt = 0;
    extra  = 0;
    slave_sda = 1'b1;
    scl_prev = scl_out;
    if (wr_q.size() > 0) wr_data = wr_q.pop_front();
    @(negedge clk);
    check("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_rw    = rw;
    cmd_len   = len;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    fin = 1'b0;
    while (!fin && lat < 3000) begin
      @(posedge clk);
      lat++;
      #1;
      if (scl_out && !scl_prev) begin
        if (exp_bits.size() > 0) check("sda_bit", sda_in, exp_bits.pop_front());
        else extra++;
      end
      if (!scl_out && scl_prev) slave_sda = (slave_q.size() > 0) ? slave_q.pop_front() : 1'b1;
      scl_prev = scl_out;
      if (wr_pop) begin
        wr_cnt++;
        if (wr_q.size() > 0) wr_data = wr_q.pop_front();
      end
      if (rd_valid) begin
        rd_cnt++;
        if (exp_rd.size() > 0) check("rd_data", rd_data, exp_rd.pop_front());
      end
      if (poke_at != 0 && lat == poke_at) begin
        cmd_valid = 1'b1;
        cmd_addr  = 7'h11;
        cmd_rw    = 1'b1;
        cmd_len   = '0;
        check("ready_while_busy", cmd_ready, 0);
      end
      if (poke_at != 0 && lat == poke_at + 20) cmd_valid = 1'b0;
      if (rst_at != 0 && lat == rst_at) begin
        check("busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_scl", scl_out, 1);
        check("rst_mid_sda", sda_out, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", cmd_ready, 1);
        check("rst_mid_rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fin = 1'b1;
      end else if (done) begin
        fin = 1'b1;
      end
    end
    if (rst_at == 0) begin
      check("latency", lat, exp_lat);
      check("nack_error", nack_error, exp_nack);
      check("wr_pops", wr_cnt, exp_wr);
      check("rd_valids", rd_cnt, exp_rdn);
      check("bits_left", exp_bits.size(), 0);
      check("rd_left", exp_rd.size(), 0);
      check("extra_bits", extra, 0);
      check("busy_at_done", busy, 0);
      @(posedge clk);
      #1;
      check("done_pulse", done, 0);
      check("nack_pulse", nack_error, 0);
    end
    clear_sb();
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_rw    = 1'b0;
    cmd_len   = '0;
    wr_data   = '0;
    slave_sda = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    check("rst_scl", scl_out, 1);
    check("rst_sda", sda_out, 1);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack_error, 0);
    check("rst_wr_pop", wr_pop, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Write 0x50, one byte 0xA5, all ACKed.
    exp_byte(8'hA0); exp_bit(0); exp_byte(8'hA5); exp_bit(0); exp_bit(0);
    slv_rel(8); slv_bit(0); slv_rel(8); slv_bit(0);
    wr_q.push_back(8'hA5);
    run(7'h50, 1'b0, 4'd1, 320, 1'b0, 1, 0, 0, 0);

    // Read 0x3C, two bytes 0x12 then 0xF0; master ACK then NACK.
    exp_byte(8'h79); exp_bit(0); exp_byte(8'h12); exp_bit(0); exp_byte(8'hF0); exp_bit(1); exp_bit(0);
    slv_rel(8); slv_bit(0); slv_byte(8'h12); slv_bit(1); slv_byte(8'hF0); slv_bit(1);
    exp_rd.push_back(8'h12); exp_rd.push_back(8'hF0);
    run(7'h3C, 1'b1, 4'd2, 464, 1'b0, 0, 2, 0, 0);

    // Address NACK on a three-byte write.
    exp_byte(8'h54); exp_bit(1); exp_bit(0);
    wr_q.push_back(8'h11); wr_q.push_back(8'h22); wr_q.push_back(8'h33);
    run(7'h2A, 1'b0, 4'd3, 176, 1'b1, 0, 0, 0, 0);

    // Address-only probe, ACKed.
    exp_byte(8'hA0); exp_bit(0); exp_bit(0);
    slv_rel(8); slv_bit(0);
    run(7'h50, 1'b0, 4'd0, 176, 1'b0, 0, 0, 0, 0);

    // Command offered while busy must not disturb the running write.
    exp_byte(8'hA0); exp_bit(0); exp_byte(8'h5A); exp_bit(0); exp_bit(0);
    slv_rel(8); slv_bit(0); slv_rel(8); slv_bit(0);
    wr_q.push_back(8'h5A);
    run(7'h50, 1'b0, 4'd1, 320, 1'b0, 1, 0, 40, 0);

    // Reset in the middle of the first read byte.
    exp_byte(8'h79); exp_bit(0); exp_byte(8'h12);
    slv_rel(8); slv_bit(0); slv_byte(8'h12);
    run(7'h3C, 1'b1, 4'd2, 0, 1'b0, 0, 0, 0, 200);

    // Normal two-byte write after the reset.
    exp_byte(8'h22); exp_bit(0); exp_byte(8'hC3); exp_bit(0); exp_byte(8'h3C); exp_bit(0); exp_bit(0);
    slv_rel(8); slv_bit(0); slv_rel(8); slv_bit(0); slv_rel(8); slv_bit(0);
    wr_q.push_back(8'hC3); wr_q.push_back(8'h3C);
    run(7'h11, 1'b0, 4'd2, 464, 1'b0, 2, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
